// File: rtl/lifegame_pkg.sv
// Shared types and constants for the Life neighbourhood window.
// Also holds the helper that assembles the 3x3 window and applies the dead-cell padding.
package lifegame_pkg;

   localparam int NB_NW = 8;
   localparam int NB_N  = 7;
   localparam int NB_NE = 6;
   localparam int NB_W  = 5;
   localparam int NB_C  = 4;
   localparam int NB_E  = 3;
   localparam int NB_SW = 2;
   localparam int NB_S  = 1;
   localparam int NB_SE = 0;

   typedef logic [8:0] neibor_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH
   } win_state_e;

   // Column vectors are {top, middle, bottom}; pad flags force out-of-grid neighbours dead.
   function automatic neibor_t pack_window(
      input logic [2:0] left_col,
      input logic [2:0] mid_col,
      input logic [2:0] right_col,
      input logic       pad_top,
      input logic       pad_bot,
      input logic       pad_left,
      input logic       pad_right
   );
      neibor_t n;
      n         = '0;
      n[NB_NW]  = left_col[2];
      n[NB_N]   = mid_col[2];
      n[NB_NE]  = right_col[2];
      n[NB_W]   = left_col[1];
      n[NB_C]   = mid_col[1];
      n[NB_E]   = right_col[1];
      n[NB_SW]  = left_col[0];
      n[NB_S]   = mid_col[0];
      n[NB_SE]  = right_col[0];
      if (pad_top) begin
         n[NB_NW] = 1'b0;
         n[NB_N]  = 1'b0;
         n[NB_NE] = 1'b0;
      end
      if (pad_bot) begin
         n[NB_SW] = 1'b0;
         n[NB_S]  = 1'b0;
         n[NB_SE] = 1'b0;
      end
      if (pad_left) begin
         n[NB_NW] = 1'b0;
         n[NB_W]  = 1'b0;
         n[NB_SW] = 1'b0;
      end
      if (pad_right) begin
         n[NB_NE] = 1'b0;
         n[NB_E]  = 1'b0;
         n[NB_SE] = 1'b0;
      end
      return n;
   endfunction

endpackage

// File: rtl/lifegame_linebuf.sv
// One grid row of cell bits; combinational read of the old value, write on the clock edge.
// Zero latency read, no backpressure: the owner decides when a column is written.
module lifegame_linebuf #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] addr,
   input  logic          wr_en,
   input  logic          wr_data,
   output logic          rd_data
);

   logic [DEPTH-1:0] mem;

   assign rd_data = mem[addr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem <= '0;
      end else if (wr_en) begin
         mem[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/lifegame_window.sv
// Raster cell stream in, 3x3 neighbourhood out; centre k appears one cycle after input k+GRID_W+1 is accepted.
// in_ready drops only while the tail of the frame is flushed (GRID_W+1 cycles); otherwise every beat is taken.
module lifegame_window
   import lifegame_pkg::*;
#(
   parameter int GRID_W = 8,
   parameter int GRID_H = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_sof,
   input  logic                        in_valid,
   input  logic                        in_data,
   output logic                        in_ready,
   output neibor_t                     neibor,
   output logic                        cal_enable,
   output logic [$clog2(GRID_H)-1:0]   out_row,
   output logic [$clog2(GRID_W)-1:0]   out_col,
   output logic                        out_eof
);

   localparam int RW = $clog2(GRID_H);
   localparam int CW = $clog2(GRID_W);
   localparam logic [RW-1:0] ROW_LAST = RW'(GRID_H - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(GRID_W - 1);

   win_state_e state, state_nxt;

   logic          accept, start, step, emit, primed, din;
   logic          last_in, last_c;
   logic [RW-1:0] in_row, c_row;
   logic [CW-1:0] in_col, c_col, lb_addr;
   logic          lb1_rd, lb2_rd;
   logic [2:0]    col_vec, prev1, prev2;

   assign last_in = (in_row == ROW_LAST) && (in_col == COL_LAST);
   assign last_c  = (c_row == ROW_LAST) && (c_col == COL_LAST);
   // Centre index exists once at least GRID_W+1 cells precede the current beat.
   assign primed  = (in_row != '0) && !((in_row == RW'(1)) && (in_col == '0));
   assign col_vec = {lb2_rd, lb1_rd, din};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN: begin
            if (start) begin
               state_nxt = RUN;
            end else if (accept && last_in) begin
               state_nxt = FLUSH;
            end
         end
         FLUSH:   if (last_c) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state != FLUSH);
      accept   = in_valid && in_ready;
      start    = accept && in_sof;
      step     = start || (state == FLUSH) || ((state == RUN) && accept);
      emit     = (state == FLUSH) || ((state == RUN) && accept && !in_sof && primed);
      din      = (state == FLUSH) ? 1'b0 : in_data;
      lb_addr  = start ? '0 : in_col;
   end

   lifegame_linebuf #(.DEPTH(GRID_W), .AW(CW)) u_lb1 (
      .clk     (clk),
      .rst     (rst),
      .addr    (lb_addr),
      .wr_en   (step),
      .wr_data (din),
      .rd_data (lb1_rd)
   );

   lifegame_linebuf #(.DEPTH(GRID_W), .AW(CW)) u_lb2 (
      .clk     (clk),
      .rst     (rst),
      .addr    (lb_addr),
      .wr_en   (step),
      .wr_data (lb1_rd),
      .rd_data (lb2_rd)
   );

   // Input position of the next beat; the row stops at the last row so FLUSH never overflows it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_row <= '0;
         in_col <= '0;
      end else if (start) begin
         in_row <= '0;
         in_col <= CW'(1);
      end else if (step) begin
         if (in_col == COL_LAST) begin
            in_col <= '0;
            if ((state == RUN) && (in_row != ROW_LAST)) begin
               in_row <= in_row + RW'(1);
            end
         end else begin
            in_col <= in_col + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c_row <= '0;
         c_col <= '0;
      end else if (start) begin
         c_row <= '0;
         c_col <= '0;
      end else if (emit) begin
         if (c_col == COL_LAST) begin
            c_col <= '0;
            c_row <= (c_row == ROW_LAST) ? '0 : c_row + RW'(1);
         end else begin
            c_col <= c_col + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev1 <= '0;
         prev2 <= '0;
      end else if (step) begin
         prev2 <= prev1;
         prev1 <= col_vec;
      end
   end

   // Stale window columns at a row wrap are exactly the ones masked by left/right padding.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         neibor     <= '0;
         cal_enable <= 1'b0;
         out_row    <= '0;
         out_col    <= '0;
         out_eof    <= 1'b0;
      end else begin
         cal_enable <= emit;
         out_eof    <= emit && last_c;
         if (emit) begin
            neibor  <= pack_window(prev2, prev1, col_vec,
                                   c_row == '0, c_row == ROW_LAST,
                                   c_col == '0, c_col == COL_LAST);
            out_row <= c_row;
            out_col <= c_col;
         end
      end
   end

endmodule

// File: tb/tb_lifegame_window.sv
// Directed bench for lifegame_window on a 5x5 grid with a scoreboard of expected windows.
module tb_lifegame_window;

   localparam int W = 5;
   localparam int H = 5;
   localparam int N = W * H;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_sof, in_valid, in_data, in_ready;
   logic [8:0] neibor;
   logic       cal_enable, out_eof;
   logic [2:0] out_row, out_col;

   lifegame_window #(.GRID_W(W), .GRID_H(H)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_sof     (in_sof),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .neibor     (neibor),
      .cal_enable (cal_enable),
      .out_row    (out_row),
      .out_col    (out_col),
      .out_eof    (out_eof)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [8:0] nb;
      int         row;
      int         col;
      logic       eof;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         pulses = 0;
   int         first_pulse = -1;
   int         acc6 = -1;
   int         lo_cnt = 0;
   logic       prev_acc = 1'b0;
   logic       prev_flush = 1'b0;
   logic       eof_seen = 1'b0;
   logic [8:0] cap [N];
   logic [N-1:0] blink, ones;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h required=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] model_nb(input logic [N-1:0] f, input int r, input int c);
      logic [8:0] n;
      n = '0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
               n[8 - ((dr + 1) * 3 + (dc + 1))] = f[(r + dr) * W + (c + dc)];
         end
      end
      return n;
   endfunction

   task automatic push_frame(input logic [N-1:0] f, input int cnt);
      exp_t e;
      for (int k = 0; k < cnt; k++) begin
         e.row = k / W;
         e.col = k % W;
         e.nb  = model_nb(f, e.row, e.col);
         e.eof = (k == N - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic sample();
      exp_t e;
      if (cal_enable === 1'b1) begin
         pulses++;
         if (first_pulse < 0) first_pulse = cyc;
         chk("pulse_cause", 32'(prev_acc | prev_flush), 32'd1);
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_pulse got=row%0d/col%0d required=no pulse", out_row, out_col);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("row", 32'(out_row), 32'(e.row));
            chk("col", 32'(out_col), 32'(e.col));
            chk("neibor", 32'(neibor), 32'(e.nb));
            chk("eof", 32'(out_eof), 32'(e.eof));
         end
         if (out_row < 3'(H) && out_col < 3'(W)) cap[int'(out_row) * W + int'(out_col)] = neibor;
         if (out_eof === 1'b1) eof_seen = 1'b1;
      end else begin
         chk("eof_without_pulse", 32'(out_eof), 32'd0);
      end
   endtask

   task automatic step_clk();
      prev_acc   = in_valid & in_ready;
      prev_flush = ~in_ready & rst;
      @(posedge clk);
      cyc++;
      #1;
      sample();
   endtask

   task automatic start_frame();
      pulses      = 0;
      first_pulse = -1;
      acc6        = -1;
      eof_seen    = 1'b0;
   endtask

   task automatic drive_cells(input logic [N-1:0] f, input int first, input int last, input int gap);
      for (int k = first; k <= last; k++) begin
         for (int g = 0; g < 4 && gap > 0 && $urandom_range(0, 99) < gap; g++) begin
            in_valid = 1'b0;
            step_clk();
         end
         in_valid = 1'b1;
         in_sof   = (k == 0);
         in_data  = f[k];
         chk("ready_in_run", 32'(in_ready), 32'd1);
         if (k == 6) acc6 = cyc;
         step_clk();
         in_valid = 1'b0;
         in_sof   = 1'b0;
         in_data  = 1'b0;
      end
   endtask

   task automatic drain();
      lo_cnt = 0;
      for (int i = 0; i < 40 && (exp_q.size() != 0 || in_ready !== 1'b1); i++) begin
         if (in_ready === 1'b0) lo_cnt++;
         step_clk();
      end
      chk("drained", 32'(exp_q.size()), 32'd0);
      chk("ready_after_flush", 32'(in_ready), 32'd1);
   endtask

   initial begin
      in_sof   = 1'b0;
      in_valid = 1'b0;
      in_data  = 1'b0;
      blink    = N'(7) << 11;
      ones     = '1;
      step_clk();
      step_clk();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_cal_enable", 32'(cal_enable), 32'd0);
      chk("rst_neibor", 32'(neibor), 32'd0);
      chk("rst_out_eof", 32'(out_eof), 32'd0);
      chk("rst_out_row", 32'(out_row), 32'd0);
      chk("rst_out_col", 32'(out_col), 32'd0);
      rst = 1'b1;
      step_clk();

      // Blinker, continuous valid
      start_frame();
      push_frame(blink, N);
      drive_cells(blink, 0, N - 1, 0);
      drain();
      chk("blink_pulses", 32'(pulses), 32'd25);
      chk("blink_eof", 32'(eof_seen), 32'd1);
      chk("blink_c22", 32'(cap[12]), 32'b000_111_000);
      chk("blink_c12", 32'(cap[7]), 32'b000_000_111);
      chk("blink_c32", 32'(cap[17]), 32'b111_000_000);

      // All-ones frame with latency and flush-length checks
      start_frame();
      push_frame(ones, N);
      drive_cells(ones, 0, N - 1, 0);
      drain();
      chk("first_pulse_latency", 32'(first_pulse), 32'(acc6 + 1));
      chk("flush_ready_low", 32'(lo_cnt), 32'd6);
      chk("ones_c00", 32'(cap[0]), 32'b000_011_011);
      chk("ones_c02", 32'(cap[2]), 32'b000_111_111);
      chk("ones_c22", 32'(cap[12]), 32'b111_111_111);
      chk("ones_c44", 32'(cap[24]), 32'b110_110_000);
      chk("ones_pulses", 32'(pulses), 32'd25);

      // Blinker with random input gaps
      start_frame();
      push_frame(blink, N);
      drive_cells(blink, 0, N - 1, 50);
      drain();
      chk("gap_pulses", 32'(pulses), 32'd25);
      chk("gap_c22", 32'(cap[12]), 32'b000_111_000);
      chk("gap_eof", 32'(eof_seen), 32'd1);

      // Abort an all-ones frame at k=12 with a new blinker frame
      start_frame();
      push_frame(ones, 6);
      drive_cells(ones, 0, 11, 0);
      chk("abort_pulses", 32'(pulses), 32'd6);
      start_frame();
      push_frame(blink, N);
      drive_cells(blink, 0, N - 1, 0);
      drain();
      chk("abort_new_pulses", 32'(pulses), 32'd25);
      chk("abort_row0_pad", 32'(cap[2]), 32'd0);
      chk("abort_c12", 32'(cap[7]), 32'b000_000_111);

      // Reset in the middle of FLUSH
      start_frame();
      push_frame(ones, N);
      drive_cells(ones, 0, N - 1, 0);
      step_clk();
      step_clk();
      rst = 1'b0;
      #1;
      chk("midrst_cal_enable", 32'(cal_enable), 32'd0);
      chk("midrst_neibor", 32'(neibor), 32'd0);
      chk("midrst_out_eof", 32'(out_eof), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      step_clk();
      step_clk();
      chk("midrst_no_eof", 32'(eof_seen), 32'd0);
      rst = 1'b1;
      step_clk();
      start_frame();
      push_frame(blink, N);
      drive_cells(blink, 0, N - 1, 0);
      drain();
      chk("post_rst_pulses", 32'(pulses), 32'd25);
      chk("post_rst_eof", 32'(eof_seen), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lifegame_window.md
Name: lifegame_window

Overview:
- Upstream neighbour of lifegame_cal.
- Accepts the Life grid as a raster-order stream, one cell bit per accepted beat.
- Uses two line buffers plus a 3x3 register window to produce, for every cell, its 9-bit neighbourhood. Cells outside the grid are padded as dead (0).
- Drives neibor/cal_enable straight into lifegame_cal, with row/col/eof side-band so the downstream write-back can place results.

Parameters:
- GRID_W, 8, grid width in cells (>=3)
- GRID_H, 8, grid height in cells (>=3)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- in_sof  in  1  marks cell (0,0) of a frame; qualified by in_valid
- in_valid  in  1  in_data valid this cycle
- in_data  in  1  cell state, 1 = alive
- in_ready  out  1  block accepts input; accept = in_valid & in_ready
- neibor  out  9  window: [8]NW [7]N [6]NE [5]W [4]C [3]E [2]SW [1]S [0]SE
- cal_enable  out  1  neibor valid this cycle (one-cycle pulse per cell)
- out_row  out  $clog2(GRID_H)  row of centre cell
- out_col  out  $clog2(GRID_W)  column of centre cell
- out_eof  out  1  high with cal_enable for the last cell (GRID_H-1, GRID_W-1)

Behaviour:
- Reset (rst=0, async) state:
  - All outputs 0 except in_ready=1.
  - Window registers, line buffers, counters and FSM cleared.
  - State returns to IDLE.
- Indexing: linear index k = row*GRID_W + col; N = GRID_W*GRID_H.
- FSM states IDLE, RUN, FLUSH.
  - IDLE: accepted beats without in_sof are dropped. An accepted in_sof beat is taken as cell 0 and moves the FSM to RUN.
  - RUN: each accepted beat advances the input counter, wrapping col at GRID_W-1 and incrementing row. Acceptance of the last cell (k = N-1) moves the FSM to FLUSH.
  - FLUSH: in_ready=0. The block self-generates one output per cycle for the remaining centres. It returns to IDLE in the cycle after out_eof.
- Output timing:
  - The window for centre k is emitted (cal_enable=1) in the cycle after input index k+GRID_W+1 is accepted.
  - Centres with k+GRID_W+1 >= N are emitted in FLUSH on consecutive cycles.
  - Every cell is emitted exactly once, in raster order. All outputs are registered.
- Input gaps: when in_valid=0 in RUN, nothing is emitted and the window does not shift.
- Padding: any neighbour with row<0, row>=GRID_H, col<0 or col>=GRID_W reads 0. There is no toroidal wrap. Left/right padding is applied at column wrap, so no data bleeds from the previous row.
- Line buffers: 2 x GRID_W bits, written at the input column and read at the same column (read-before-write).
- in_sof accepted while in RUN: the current frame is aborted and no further outputs are emitted for it. The beat is treated as cell 0 of a new frame, and the line buffers are logically cleared (via row-0 padding, with no cycle cost).
- in_sof during FLUSH is not accepted, because in_ready=0.
- Reset asserted mid-RUN or mid-FLUSH: immediate return to reset state; no out_eof is produced for the interrupted frame.
- Counter widths: $clog2 of the dimension. Row/col compare against GRID_W-1 / GRID_H-1 explicitly; power-of-two sizes are not relied on.

Decomposition:
- Package lifegame_pkg:
  - Neighbour bit-position constants NB_NW..NB_SE.
  - Typedef neibor_t (logic [8:0]).
  - FSM enum win_state_e {IDLE, RUN, FLUSH}.
- Sub-module lifegame_linebuf: one GRID_W-deep 1-bit line buffer with read-before-write. It is instantiated twice.

Test Plan:
- Blinker, 5x5 grid (GRID_W=5, GRID_H=5), alive cells (2,1),(2,2),(2,3), continuous valid:
  - centre (2,2) neibor = 9'b000_111_000
  - centre (1,2) neibor = 9'b000_000_111
  - centre (3,2) neibor = 9'b111_000_000
  - exactly 25 cal_enable pulses; out_eof on (4,4)
- All-ones 5x5 frame:
  - corner (0,0) = 9'b000_011_011
  - edge (0,2) = 9'b000_111_111
  - interior (2,2) = 9'b111_111_111
  - corner (4,4) = 9'b110_110_000
- Latency check on the same 5x5 frame:
  - first cal_enable occurs one cycle after acceptance of input k=6
  - FLUSH holds in_ready=0 for exactly 6 cycles, then in_ready returns to 1
- Random in_valid gaps (about 50% duty) on the blinker frame: neibor sequence identical to the gap-free run; no pulse in any cycle without a preceding accept or FLUSH step.
- in_sof reasserted at k=12 of a frame: no further outputs from the aborted frame; the new frame's outputs match a clean run, including row-0 padding (no stale line-buffer data).
- rst driven low mid-FLUSH: outputs go to 0 immediately, in_ready=1, no out_eof; the next in_sof frame produces the correct 25 outputs.
